decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 123 ++++++++++++
 tb/tb_decode_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// decode_pipe: instruction queue feeding a single-register decode stage.
// Defining DECODE_HAZARD_EN enables load-use bubble insertion ahead of the decode stage.
module decode_pipe #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [PC_WIDTH-1:0]          in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic [4:0]                   rs,
    output logic [4:0]                   rt,
    output logic [4:0]                   rd,
    output logic [15:0]                  imm16,
    output logic [25:0]                  target_address,
    output logic [12:0]                  out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]         q_instr [DEPTH];
    logic [PC_WIDTH-1:0] q_pc    [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [31:0]         instr, head;
    logic                push, load, hazard;
    logic [5:0]          op, fn;
    logic                is_lw, is_sw, is_addi, is_xori, is_bne, is_j, is_jal;
    logic                is_add, is_sub, is_slt, is_jr;
    logic [12:0]         ctrl;

    assign head     = q_instr[rd_ptr];
    assign in_ready = count < CW'(DEPTH);
    assign push     = in_valid && in_ready;
    assign load     = count != '0 && (!out_valid || out_ready) && !hazard;

    assign rs             = instr[25:21];
    assign rt             = instr[20:16];
    assign rd             = instr[15:11];
    assign imm16          = instr[15:0];
    assign target_address = instr[25:0];

`ifdef DECODE_HAZARD_EN
    logic [4:0] ld_rt;
    assign ld_rt  = instr[20:16];
    // The head may only read the load's destination through rs, or through rt for R-type/SW/BNE.
    assign hazard = out_valid && out_ready && instr[31:26] == 6'h23 && ld_rt != 5'd0 &&
                    (head[25:21] == ld_rt ||
                     (head[20:16] == ld_rt && (op == 6'h00 || op == 6'h2B || op == 6'h05)));
`else
    assign hazard = 1'b0;
`endif

    always_comb begin
        op      = head[31:26];
        fn      = head[5:0];
        is_lw   = op == 6'h23;
        is_sw   = op == 6'h2B;
        is_addi = op == 6'h08;
        is_xori = op == 6'h0E;
        is_bne  = op == 6'h05;
        is_j    = op == 6'h02;
        is_jal  = op == 6'h03;
        is_add  = op == 6'h00 && fn == 6'h20;
        is_sub  = op == 6'h00 && fn == 6'h22;
        is_slt  = op == 6'h00 && fn == 6'h2A;
        is_jr   = op == 6'h00 && fn == 6'h08;
        ctrl     = '0;
        ctrl[0]  = is_lw || is_addi || is_xori || is_jal || is_add || is_sub || is_slt;
        ctrl[1]  = is_add || is_sub || is_slt;
        ctrl[2]  = is_lw || is_sw || is_addi || is_xori;
        ctrl[5:3] = is_xori ? 3'b010 : is_slt ? 3'b011 : (is_sub || is_bne) ? 3'b001 : 3'b000;
        ctrl[6]  = is_sw;
        ctrl[7]  = is_lw;
        ctrl[8]  = is_jal;
        ctrl[9]  = is_jr;
        ctrl[10] = is_bne;
        ctrl[11] = is_xori;
        ctrl[12] = !(is_lw || is_sw || is_addi || is_xori || is_bne || is_j || is_jal ||
                     is_add || is_sub || is_slt || is_jr);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= in_instr;
            q_pc[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            instr     <= '0;
            out_ctrl  <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (load) begin
                rd_ptr   <= rd_ptr + AW'(1);
                instr    <= head;
                out_pc   <= q_pc[rd_ptr];
                out_ctrl <= ctrl;
            end
            out_valid <= load || (out_valid && !out_ready);
            count     <= count + CW'(push) - CW'(load);
        end
    end
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: randomized and directed stimulus; a queue-based reference model feeds a
// scoreboard that an independent negedge monitor checks against the decode outputs.
module tb_decode_pipe;
    localparam int DEPTH = 4;
    localparam int PCW   = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      in_instr = '0;
    logic [PCW-1:0]   in_pc = '0;
    logic             in_ready, out_valid;
    logic [PCW-1:0]   out_pc;
    logic [4:0]       rs, rt, rd;
    logic [15:0]      imm16;
    logic [25:0]      target_address;
    logic [12:0]      out_ctrl;
    logic [2:0]       count;

    decode_pipe #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
        .target_address(target_address), .out_ctrl(out_ctrl), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]    instr;
        logic [PCW-1:0] pc;
    } ent_t;

    ent_t        fifo[$];
    ent_t        sb[$];
    ent_t        e;
    bit          mo;
    bit          ld, haz, acc;
    logic [31:0] cur;
    int          tests = 0;
    int          fails = 0;
    bit          stall_prev = 0;
    logic [PCW-1:0] s_pc;
    logic [12:0] s_ctrl;
    logic [25:0] s_tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] ref_ctrl(input logic [31:0] i);
        logic [5:0] o;
        logic [5:0] f;
        o = i[31:26];
        f = i[5:0];
        if (o == 6'h23) return 13'h085;
        if (o == 6'h2B) return 13'h044;
        if (o == 6'h08) return 13'h005;
        if (o == 6'h0E) return 13'h815;
        if (o == 6'h05) return 13'h408;
        if (o == 6'h02) return 13'h000;
        if (o == 6'h03) return 13'h101;
        if (o == 6'h00 && f == 6'h20) return 13'h003;
        if (o == 6'h00 && f == 6'h22) return 13'h00B;
        if (o == 6'h00 && f == 6'h2A) return 13'h01B;
        if (o == 6'h00 && f == 6'h08) return 13'h200;
        return 13'h1000;
    endfunction

    // Reference model: a plain queue of waiting instructions plus one "displayed" flag.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo.delete();
            sb.delete();
            mo = 0;
        end else if (flush) begin
            fifo.delete();
            sb.delete();
            mo = 0;
        end else begin
            acc = mo && out_ready;
            haz = 0;
`ifdef DECODE_HAZARD_EN
            if (acc && cur[31:26] == 6'h23 && cur[20:16] != 5'd0 && fifo.size() > 0)
                haz = fifo[0].instr[25:21] == cur[20:16] ||
                      (fifo[0].instr[20:16] == cur[20:16] &&
                       (fifo[0].instr[31:26] == 6'h00 || fifo[0].instr[31:26] == 6'h2B ||
                        fifo[0].instr[31:26] == 6'h05));
`endif
            ld = fifo.size() > 0 && (!mo || out_ready) && !haz;
            if (in_valid && fifo.size() < DEPTH)
                fifo.push_back('{instr: in_instr, pc: in_pc});
            if (ld) begin
                cur = fifo[0].instr;
                sb.push_back(fifo.pop_front());
                mo = 1;
            end else if (acc) begin
                mo = 0;
            end
        end
    end

    // Monitor: compares everything the DUT presents against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            chk("count", 32'(count), fifo.size() - ((in_valid && fifo.size() < DEPTH && !flush) ? 0 : 0));
            chk("out_valid", 32'(out_valid), 32'(mo));
            chk("in_ready", 32'(in_ready), 32'(fifo.size() < DEPTH));
            if (stall_prev && out_valid) begin
                chk("hold_pc", out_pc, s_pc);
                chk("hold_ctrl", 32'(out_ctrl), 32'(s_ctrl));
                chk("hold_target", 32'(target_address), 32'(s_tgt));
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard: out_valid=1 with pc %h but nothing expected", out_pc);
                end else begin
                    e = sb[0];
                    chk("out_pc", out_pc, e.pc);
                    chk("out_ctrl", 32'(out_ctrl), 32'(ref_ctrl(e.instr)));
                    chk("rs", 32'(rs), 32'(e.instr[25:21]));
                    chk("rt", 32'(rt), 32'(e.instr[20:16]));
                    chk("rd", 32'(rd), 32'(e.instr[15:11]));
                    chk("imm16", 32'(imm16), 32'(e.instr[15:0]));
                    chk("target", 32'(target_address), 32'(e.instr[25:0]));
                    if (out_ready)
                        void'(sb.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            s_pc = out_pc;
            s_ctrl = out_ctrl;
            s_tgt = target_address;
        end else begin
            stall_prev = 0;
        end
    end

    task automatic do_reset();
        reset = 1;
        in_valid = 0;
        flush = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic push_one(input logic [31:0] i, input logic [PCW-1:0] p);
        bit ok;
        in_valid = 1;
        in_instr = i;
        in_pc = p;
        for (int n = 0; n < 50; n++) begin
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) return;
        end
        tests++;
        fails++;
        $display("FAIL push_timeout: in_ready stayed 0, required 1");
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        r[25:21] = 5'($urandom_range(0, 3));
        r[20:16] = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 11))
            0: r[31:26] = 6'h23;
            1: r[31:26] = 6'h2B;
            2: r[31:26] = 6'h08;
            3: r[31:26] = 6'h0E;
            4: r[31:26] = 6'h05;
            5: r[31:26] = 6'h02;
            6: r[31:26] = 6'h03;
            7: begin r[31:26] = 6'h00; r[5:0] = 6'h20; end
            8: begin r[31:26] = 6'h00; r[5:0] = 6'h22; end
            9: begin r[31:26] = 6'h00; r[5:0] = 6'h2A; end
            10: begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        int seen, gap, first, second;
        bit v[8];
        logic [PCW-1:0] pc;

        // Reset values, checked while reset is still high.
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_ctrl", 32'(out_ctrl), 0);
        chk("rst_out_pc", out_pc, 0);
        do_reset();

        // Single ADDI, first push right after reset release.
        out_ready = 1;
        push_one(32'h20080005, 32'h100);
        in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        chk("addi_valid", 32'(out_valid), 1);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_rs", 32'(rs), 0);
        chk("addi_rt", 32'(rt), 8);
        chk("addi_imm", 32'(imm16), 32'h5);
        chk("addi_ctrl", 32'(out_ctrl), 32'h005);
        @(posedge clk);
        #1;

        // Back-pressure: DEPTH+1 pushes with the consumer stalled, then drain across wrap.
        idle(2);
        out_ready = 0;
        for (int k = 0; k <= DEPTH; k++)
            push_one(rand_instr(), 32'h400 + 32'(4 * k));
        in_valid = 0;
        chk("full_count", 32'(count), DEPTH);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_pc_head", out_pc, 32'h400);
        idle(3);
        chk("full_hold_pc", out_pc, 32'h400);
        out_ready = 1;
        idle(DEPTH + 3);

        // Illegal opcode and J.
        push_one(32'hFC000000, 32'h200);
        push_one(32'h08000010, 32'h204);
        in_valid = 0;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (out_valid && out_pc == 32'h200) begin
                chk("illegal_ctrl", 32'(out_ctrl), 32'h1000);
                seen |= 1;
            end
            if (out_valid && out_pc == 32'h204) begin
                chk("j_ctrl", 32'(out_ctrl), 0);
                chk("j_target", 32'(target_address), 32'h0000010);
                seen |= 2;
            end
        end
        chk("illegal_j_seen", seen, 3);
        @(posedge clk);
        #1;

        // Load-use pair: one bubble only when the hazard logic is built in.
        push_one(32'h8C080000, 32'h300);
        push_one(32'h01084820, 32'h304);
        in_valid = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            v[n] = out_valid;
        end
        first = -1;
        second = -1;
        for (int n = 0; n < 8; n++) begin
            if (v[n] && first < 0) first = n;
            else if (v[n] && first >= 0 && second < 0 && !v[n-1]) second = n;
            else if (v[n] && first >= 0 && second < 0 && n == first + 1) second = n;
        end
        gap = (first >= 0 && second >= 0) ? second - first - 1 : -1;
`ifdef DECODE_HAZARD_EN
        chk("load_use_gap", gap, 1);
`else
        chk("load_use_gap", gap, 0);
`endif
        @(posedge clk);
        #1;

        // Flush with a simultaneous push at count=3.
        out_ready = 0;
        for (int k = 0; k < 4; k++)
            push_one(32'h20010000 + 32'(k), 32'h500 + 32'(4 * k));
        chk("pre_flush_count", 32'(count), 3);
        flush = 1;
        in_valid = 1;
        in_instr = 32'h2002BEEF;
        in_pc = 32'hBAD0;
        @(posedge clk);
        #1;
        flush = 0;
        in_valid = 0;
        chk("flush_count", 32'(count), 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        out_ready = 1;
        idle(4);
        chk("flush_no_emerge", 32'(out_valid), 0);

        // Asynchronous reset between edges with count=2 and out_valid=1.
        out_ready = 0;
        for (int k = 0; k < 3; k++)
            push_one(32'h00221820 + 32'(k << 11), 32'h600 + 32'(4 * k));
        in_valid = 0;
        chk("pre_rst_count", 32'(count), 2);
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2 reset = 1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_pc", out_pc, 0);
        chk("arst_ctrl", 32'(out_ctrl), 0);
        chk("arst_fields", {rs, rt, rd, imm16}, 0);
        chk("arst_target", 32'(target_address), 0);
        @(posedge clk);
        #1 reset = 0;
        out_ready = 1;
        idle(4);
        chk("arst_no_emerge", 32'(out_valid), 0);

        // Randomized traffic; the model and monitor do all checking.
        pc = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            flush = ($urandom_range(0, 79) == 0);
            in_valid = $urandom_range(0, 2) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            in_instr = rand_instr();
            in_pc = pc;
            pc += 4;
            @(posedge clk);
            #1;
        end
        flush = 0;
        in_valid = 0;
        out_ready = 1;
        idle(DEPTH + 4);
        chk("drain_count", 32'(count), 0);
        chk("drain_sb", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
